song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Plays a song stored in the combinational music-sheet ROM (index -> note period, duration, done).
- Steps the ROM index and times each note's duration in ticks.
- Generates the square-wave speaker output from the note period, and inserts a short silent gap between notes.
- Sits between the top-level play/stop controls and the ROM/speaker pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; note periods are counted in these clocks.
- TICK_HZ, 8, duration unit rate; QUARTER=2 ticks = 250 ms.
- GAP_CYCLES, 2_500_000, silent cycles between notes (50 ms); 0 = no gap.
- LOOP, 0, 1 = restart at index 0 after done; 0 = stop.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level/pulse; begins playback from index 0 when idle
- stop  in  1  aborts playback
- pause  in  1  freezes playback while high
- note_in  in  20  ROM note period in clk cycles; value <= 1 = rest
- duration_in  in  5  ROM duration in ticks
- done_in  in  1  ROM end-of-song marker
- number  out  10  ROM index
- speaker  out  1  square-wave tone
- busy  out  1  high whenever state != IDLE
- song_end  out  1  one-cycle pulse on end of song

Behaviour:
- Reset (async):
  - state = IDLE.
  - number = 0, speaker = 0, busy = 0, song_end = 0.
  - All counters = 0.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - speaker = 0.
  - start=1 and stop=0 -> number <= 0, go to LOAD.
  - start with stop=1 in the same cycle: stop wins; stay IDLE.
- LOAD (exactly 1 cycle; the ROM is combinational on number):
  - Register note_in, duration_in, done_in.
  - If done_in=1:
    - song_end=1 on the next cycle.
    - LOOP=1 -> number <= 0, stay in LOAD.
    - LOOP=0 -> number <= 0, go to IDLE.
  - Else if duration_in=0: number <= number+1, stay in LOAD (entry skipped).
  - Else: dur_cnt <= duration_in, clear the tick prescaler and tone counter, go to PLAY.
  - pause has no effect in LOAD.
- PLAY:
  - Tick prescaler counts 0..CLK_HZ/TICK_HZ-1.
  - At each wrap: if dur_cnt==1, go to GAP; else dur_cnt <= dur_cnt-1.
  - Note length is exactly duration*(CLK_HZ/TICK_HZ) cycles.
  - Tone, latched period P:
    - P<=1: speaker held 0 (rest).
    - Otherwise the tone counter counts 0..(P>>1)-1 and speaker toggles at each wrap.
    - Odd P is truncated.
    - The first toggle occurs P>>1 cycles after PLAY entry, starting from speaker=0.
- GAP:
  - speaker = 0 for GAP_CYCLES cycles, then number <= number+1 (mod 1024) and go to LOAD.
  - GAP_CYCLES=0 -> PLAY goes directly to LOAD with the increment.
- pause=1 in PLAY/GAP:
  - All counters frozen; speaker forced to 0.
  - On release, resume with the same counter values; total note time extends by exactly the pause length.
- stop=1 in any non-IDLE state:
  - Next state is IDLE; number <= 0; speaker <= 0.
  - stop has priority over pause and done.
- start while busy: ignored.
- number wrap: 1023+1 -> 0, no error flag.
- Latched note/duration must not change if note_in changes mid-note (only sampled in LOAD).
- Worst-case index-to-tone latency: 1 LOAD cycle after number updates.

Decomposition:
- Shared package music_pkg:
  - Duration constants QUARTER=2, HALF=4, ONE=8, TWO=16, FOUR=32.
  - Note-period constants B4, C5S, D5S, E5, F5S, G5S, A5S, B5 (CLK_HZ/freq).
  - Rest value SP=1.
  - State enum.
  - Widths NOTE_W=20, DUR_W=5, IDX_W=10.
- Sub-module tone_gen:
  - Inputs: clk, reset, period[19:0], enable, clear.
  - Output: speaker.
  - Holds the tone counter and toggle flop; outputs 0 when enable=0 or period<=1.

Test Plan (sim parameters CLK_HZ=1000, TICK_HZ=10 -> 100 cycles/tick, GAP_CYCLES=4, ROM stub):
- start, entry0 = {note 20, dur 2} -> speaker toggles every 10 cycles for 200 cycles, then 4 cycles of 0, then number=1.
- Entry with note 1 (SP), dur 1 -> speaker stays 0 for 100 cycles, busy=1 throughout.
- Entries 0..2 normal, entry 3 done=1, LOOP=0 -> single song_end pulse, busy=0 next cycle, number=0. Rerun with LOOP=1 -> number returns to 0 and entry0 replays.
- pause high for 50 cycles mid-note (note 20, dur 2) -> speaker 0 during pause; note ends at cycle 250 instead of 200; toggle phase continues from the frozen count.
- stop asserted during GAP -> IDLE next cycle, number=0, speaker=0. start and stop together in IDLE -> stays IDLE.
- reset asserted asynchronously mid-PLAY (between clock edges) -> speaker=0, busy=0, number=0 immediately. After release, start replays from index 0.

Source files
------------

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, note/duration constants and sequencer state type
`timescale 1ns/1ps
package music_pkg;

    localparam int NOTE_W = 20;
    localparam int DUR_W  = 5;
    localparam int IDX_W  = 10;

    // Clock the note-period constants are expressed in.
    localparam int SYS_CLK_HZ = 50_000_000;

    // Durations in ticks. FOUR exceeds the 5-bit ROM field; a four-beat note
    // has to be written as two consecutive TWO entries.
    localparam int QUARTER = 2;
    localparam int HALF    = 4;
    localparam int ONE     = 8;
    localparam int TWO     = 16;
    localparam int FOUR    = 32;

    // Note periods in system clocks (SYS_CLK_HZ / frequency).
    localparam logic [NOTE_W-1:0] B4  = NOTE_W'(SYS_CLK_HZ / 494);
    localparam logic [NOTE_W-1:0] C5S = NOTE_W'(SYS_CLK_HZ / 554);
    localparam logic [NOTE_W-1:0] D5S = NOTE_W'(SYS_CLK_HZ / 622);
    localparam logic [NOTE_W-1:0] E5  = NOTE_W'(SYS_CLK_HZ / 659);
    localparam logic [NOTE_W-1:0] F5S = NOTE_W'(SYS_CLK_HZ / 740);
    localparam logic [NOTE_W-1:0] G5S = NOTE_W'(SYS_CLK_HZ / 831);
    localparam logic [NOTE_W-1:0] A5S = NOTE_W'(SYS_CLK_HZ / 932);
    localparam logic [NOTE_W-1:0] B5  = NOTE_W'(SYS_CLK_HZ / 988);
    localparam logic [NOTE_W-1:0] SP  = NOTE_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator toggling every period/2 clocks
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   period      note period in clocks; <= 1 means rest (output held 0)
//   enable      advance the counter; output forced 0 while low
//   clear       restart counter and phase (speaker starts from 0)
//   speaker     tone output
`timescale 1ns/1ps
module tone_gen
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] period,
    input  logic              enable,
    input  logic              clear,
    output logic              speaker
);

    logic [NOTE_W-2:0] cnt;
    logic [NOTE_W-2:0] half;
    logic              tog;
    logic              audible;

    // Odd periods are truncated: the half period is period >> 1.
    assign half    = period[NOTE_W-1:1];
    assign audible = (period > NOTE_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (enable && audible) begin
            if (cnt == half - (NOTE_W-1)'(1)) begin
                cnt <= '0;
                tog <= ~tog;
            end else begin
                cnt <= cnt + (NOTE_W-1)'(1);
            end
        end
    end

    // Gating here (not in the flop) lets pause silence the pin while the
    // phase is kept for resume.
    assign speaker = tog & enable & audible;

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps a music ROM, times notes and drives the speaker
//
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   start         begin playback from index 0 when idle
//   stop          abort playback (wins over pause, done and start)
//   pause         freeze playback while high (PLAY/GAP only)
//   note_in       ROM note period in clocks; <= 1 is a rest
//   duration_in   ROM duration in ticks; 0 skips the entry
//   done_in       ROM end-of-song marker
//   number        ROM index
//   speaker       square-wave tone
//   busy          high whenever not idle
//   song_end      one-cycle pulse when the end marker is reached
`timescale 1ns/1ps
module song_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 8,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int LOOP       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [DUR_W-1:0]  duration_in,
    input  logic              done_in,
    output logic [IDX_W-1:0]  number,
    output logic              speaker,
    output logic              busy,
    output logic              song_end
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state, state_next;
    logic [NOTE_W-1:0]   note_q, note_next;
    logic [DUR_W-1:0]    dur_cnt, dur_next;
    logic [TICK_W-1:0]   tick_cnt, tick_next;
    logic [GAP_W-1:0]    gap_cnt, gap_next;
    logic [IDX_W-1:0]    number_next;
    logic                end_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        number_next = number;
        note_next   = note_q;
        dur_next    = dur_cnt;
        tick_next   = tick_cnt;
        gap_next    = gap_cnt;
        end_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    number_next = '0;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                note_next = note_in;
                if (done_in) begin
                    end_next    = 1'b1;
                    number_next = '0;
                    state_next  = (LOOP != 0) ? LOAD : IDLE;
                end else if (duration_in == '0) begin
                    number_next = number + IDX_W'(1);
                end else begin
                    dur_next   = duration_in;
                    tick_next  = '0;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (!pause) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        if (dur_cnt == DUR_W'(1)) begin
                            if (GAP_CYCLES == 0) begin
                                number_next = number + IDX_W'(1);
                                state_next  = LOAD;
                            end else begin
                                gap_next   = '0;
                                state_next = GAP;
                            end
                        end else begin
                            dur_next = dur_cnt - DUR_W'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
            end
            GAP: begin
                if (!pause) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_next    = '0;
                        number_next = number + IDX_W'(1);
                        state_next  = LOAD;
                    end else begin
                        gap_next = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (stop && state != IDLE) begin
            state_next  = IDLE;
            number_next = '0;
            end_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            number   <= '0;
            note_q   <= '0;
            dur_cnt  <= '0;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            song_end <= 1'b0;
        end else begin
            number   <= number_next;
            note_q   <= note_next;
            dur_cnt  <= dur_next;
            tick_cnt <= tick_next;
            gap_cnt  <= gap_next;
            song_end <= end_next;
        end
    end

    assign busy = (state != IDLE);

    // The tone restarts from phase 0 on every LOAD, so every note begins low.
    tone_gen u_tone (
        .clk     (clk),
        .reset   (reset),
        .period  (note_q),
        .enable  ((state == PLAY) && !pause),
        .clear   (state == LOAD),
        .speaker (speaker)
    );

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer
`timescale 1ns/1ps
module tb_song_sequencer;

    localparam int TICK = 100;
    localparam int GAPC = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        pause;

    logic [19:0] note0, note1;
    logic [4:0]  dur0, dur1;
    logic        done0, done1;
    logic [9:0]  num0, num1;
    logic        spk0, spk1, busy0, busy1, end0, end1;

    logic [19:0] rom_note [1024];
    logic [4:0]  rom_dur  [1024];
    logic        rom_done [1024];

    assign note0 = rom_note[num0];
    assign dur0  = rom_dur[num0];
    assign done0 = rom_done[num0];
    assign note1 = rom_note[num1];
    assign dur1  = rom_dur[num1];
    assign done1 = rom_done[num1];

    song_sequencer #(.CLK_HZ(1000), .TICK_HZ(10), .GAP_CYCLES(GAPC), .LOOP(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .note_in(note0), .duration_in(dur0), .done_in(done0),
        .number(num0), .speaker(spk0), .busy(busy0), .song_end(end0)
    );

    song_sequencer #(.CLK_HZ(1000), .TICK_HZ(10), .GAP_CYCLES(GAPC), .LOOP(1)) u_loop (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .note_in(note1), .duration_in(dur1), .done_in(done1),
        .number(num1), .speaker(spk1), .busy(busy1), .song_end(end1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] number;
        logic       busy;
        logic       speaker;
        logic       song_end;
    } exp_t;

    typedef struct {
        logic [19:0] note;
        logic [4:0]  dur;
        int          exp_len;
        int          exp_high;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   len_c, high_c, ends_c;
    exp_t exp_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) begin
            rom_note[i] = 20'd0;
            rom_dur[i]  = 5'd0;
            rom_done[i] = 1'b1;
        end
    endtask

    task automatic set_entry(input int idx, input int note, input int dur);
        rom_note[idx] = 20'(note);
        rom_dur[idx]  = 5'(dur);
        rom_done[idx] = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        len_c  = 0;
        high_c = 0;
        ends_c = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (busy0 && num0 == 10'd0) len_c++;
        if (spk0) high_c++;
        if (end0) ends_c++;
    endtask

    task automatic start_play();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy0 && n < bound);
        checks++;
        if (busy0) begin
            failures++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", bound);
        end
    endtask

    // Expected per-cycle outputs for LOOP=0, from the song as written in the ROM:
    // one LOAD cycle per entry, duration*TICK play cycles with a half-period
    // square wave starting low, GAPC silent cycles, then the end pulse.
    function automatic void build_model();
        int p, half;
        logic s;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{number: 10'(i), busy: 1'b1, speaker: 1'b0, song_end: 1'b0});
            if (rom_done[i]) begin
                exp_q.push_back('{number: 10'd0, busy: 1'b0, speaker: 1'b0, song_end: 1'b1});
                exp_q.push_back('{number: 10'd0, busy: 1'b0, speaker: 1'b0, song_end: 1'b0});
                return;
            end
            if (rom_dur[i] != 0) begin
                p = int'(rom_note[i]);
                half = p / 2;
                for (int k = 0; k < int'(rom_dur[i]) * TICK; k++) begin
                    s = (p > 1) && (((k / half) % 2) == 1);
                    exp_q.push_back('{number: 10'(i), busy: 1'b1, speaker: s, song_end: 1'b0});
                end
                for (int g = 0; g < GAPC; g++)
                    exp_q.push_back('{number: 10'(i), busy: 1'b1, speaker: 1'b0, song_end: 1'b0});
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t act, exp;
        bit   found;
        int   zeros;

        vecs[0] = '{note: 20'd20, dur: 5'd2, exp_len: 205, exp_high: 100};
        vecs[1] = '{note: 20'd1,  dur: 5'd1, exp_len: 105, exp_high: 0};
        vecs[2] = '{note: 20'd7,  dur: 5'd1, exp_len: 105, exp_high: 49};
        vecs[3] = '{note: 20'd2,  dur: 5'd1, exp_len: 105, exp_high: 50};
        vecs[4] = '{note: 20'd3,  dur: 5'd1, exp_len: 105, exp_high: 50};
        vecs[5] = '{note: 20'd0,  dur: 5'd3, exp_len: 305, exp_high: 0};
        vecs[6] = '{note: 20'd20, dur: 5'd0, exp_len: 1,   exp_high: 0};
        vecs[7] = '{note: 20'd21, dur: 5'd1, exp_len: 105, exp_high: 50};

        clear_rom();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_number", int'(num0), 0);
        check("reset_speaker", int'(spk0), 0);
        check("reset_busy", int'(busy0), 0);
        check("reset_song_end", int'(end0), 0);

        // Single-note songs from the vector table.
        foreach (vecs[v]) begin
            do_reset();
            clear_rom();
            set_entry(0, int'(vecs[v].note), int'(vecs[v].dur));
            start_play();
            wait_idle(1000);
            check($sformatf("vec%0d_len", v), len_c, vecs[v].exp_len);
            check($sformatf("vec%0d_high", v), high_c, vecs[v].exp_high);
            check($sformatf("vec%0d_ends", v), ends_c, 1);
        end

        // Pause for 50 cycles in the middle of a two-tick note.
        do_reset();
        clear_rom();
        set_entry(0, 20, 2);
        start_play();
        repeat (56) step();
        check("pause_before", int'(spk0), 1);
        pause = 1'b1;
        zeros = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (spk0) zeros++;
        end
        check("pause_silent", zeros, 0);
        check("pause_busy", int'(busy0), 1);
        pause = 1'b0;
        step();
        check("pause_resume_phase", int'(spk0), 1);
        wait_idle(1000);
        check("pause_len", len_c, 255);
        check("pause_high", high_c, 100);

        // Stop during the gap after the second note.
        do_reset();
        clear_rom();
        set_entry(0, 20, 1);
        set_entry(1, 20, 1);
        start_play();
        repeat (207) step();
        check("gap_number", int'(num0), 1);
        check("gap_speaker", int'(spk0), 0);
        check("gap_busy", int'(busy0), 1);
        stop = 1'b1;
        step();
        check("stop_busy", int'(busy0), 0);
        check("stop_number", int'(num0), 0);
        check("stop_speaker", int'(spk0), 0);
        check("stop_no_end", ends_c, 0);
        start = 1'b1;
        step();
        step();
        check("start_stop_idle", int'(busy0), 0);
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset between clock edges during the second note.
        do_reset();
        clear_rom();
        set_entry(0, 20, 1);
        set_entry(1, 20, 2);
        start_play();
        repeat (121) step();
        check("pre_reset_number", int'(num0), 1);
        check("pre_reset_speaker", int'(spk0), 1);
        #3 reset = 1'b1;
        #1;
        check("async_reset_speaker", int'(spk0), 0);
        check("async_reset_busy", int'(busy0), 0);
        check("async_reset_number", int'(num0), 0);
        @(negedge clk);
        reset = 1'b0;
        start_play();
        check("replay_load_number", int'(num0), 0);
        check("replay_load_busy", int'(busy0), 1);
        repeat (11) step();
        check("replay_tone", int'(spk0), 1);

        // Three notes then the end marker, both LOOP settings side by side.
        do_reset();
        clear_rom();
        set_entry(0, 20, 1);
        set_entry(1, 1, 1);
        set_entry(2, 7, 1);
        start_play();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (end1) found = 1'b1;
        end
        check("loop_end_seen", int'(found), 1);
        check("loop_busy_at_end", int'(busy1), 1);
        check("loop_number_at_end", int'(num1), 0);
        check("once_end_pulse", int'(end0), 1);
        check("once_busy_at_end", int'(busy0), 0);
        check("once_number_at_end", int'(num0), 0);
        step();
        check("loop_reload_number", int'(num1), 0);
        check("loop_pulse_width", int'(end1), 0);
        repeat (11) step();
        check("loop_replay_tone", int'(spk1), 1);
        check("once_single_pulse", ends_c, 1);
        check("once_stays_idle", int'(busy0), 0);

        // Random songs against the timeline model.
        for (int t = 0; t < 6; t++) begin
            int n;
            int errs;
            do_reset();
            clear_rom();
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++)
                set_entry(i, int'($urandom_range(0, 30)), int'($urandom_range(0, 2)));
            build_model();
            start = 1'b1;
            errs = 0;
            foreach (exp_q[c]) begin
                @(negedge clk);
                start = 1'b0;
                act = '{number: num0, busy: busy0, speaker: spk0, song_end: end0};
                exp = exp_q[c];
                checks++;
                if (act !== exp) begin
                    failures++;
                    errs++;
                    if (errs <= 5)
                        $display("FAIL rand%0d cycle %0d: got num=%0d busy=%0b spk=%0b end=%0b expected num=%0d busy=%0b spk=%0b end=%0b",
                                 t, c, act.number, act.busy, act.speaker, act.song_end,
                                 exp.number, exp.busy, exp.speaker, exp.song_end);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
